// File: rtl/ps2_kbd_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: status/control bit
// positions, receiver FSM states and the frame parity helper.
package ps2_kbd_pkg;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    localparam int unsigned ST_AVAIL = 0;
    localparam int unsigned ST_FULL  = 1;
    localparam int unsigned ST_OVR   = 2;
    localparam int unsigned ST_PERR  = 3;
    localparam int unsigned ST_FERR  = 4;
    localparam int unsigned ST_IEN   = 5;
    localparam int unsigned ST_BUSY  = 6;
    localparam int unsigned ST_IRQ   = 7;

    localparam int unsigned CTL_CLR  = 0;
    localparam int unsigned CTL_IEN  = 7;

    // PS/2 frames use odd parity over the 8 data bits plus the parity bit
    function automatic logic parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_kbd_rx.sv
// PS/2 frame receiver: pin synchronisers, 3-sample glitch filter, falling
// edge detect, frame FSM and mid-frame timeout.
module ps2_rx
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 8000
) (
    input  logic       clk,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       perr_p_o,
    output logic       ferr_p_o,
    output logic       busy_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]   clk_sync_q, dat_sync_q;
    logic [1:0]   clk_hist_q, dat_hist_q;
    logic         clk_filt_q, dat_filt_q;
    logic         clk_filt_d, dat_filt_d;
    logic         fall;

    rx_state_e    state_q;
    logic [2:0]   bitcnt_q;
    logic [7:0]   shreg_q;
    logic         par_q;
    logic [TW-1:0] timer_q;
    logic         byte_valid_q, perr_q, ferr_q;

    // A filtered line only moves once three consecutive synced samples agree
    always_comb begin
        clk_filt_d = clk_filt_q;
        dat_filt_d = dat_filt_q;
        if (clk_sync_q[1] == clk_hist_q[0] && clk_hist_q[0] == clk_hist_q[1])
            clk_filt_d = clk_sync_q[1];
        if (dat_sync_q[1] == dat_hist_q[0] && dat_hist_q[0] == dat_hist_q[1])
            dat_filt_d = dat_sync_q[1];
        fall = clk_filt_q & ~clk_filt_d;
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_hist_q <= '1;
            dat_hist_q <= '1;
            clk_filt_q <= 1'b1;
            dat_filt_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
            clk_hist_q <= {clk_hist_q[0], clk_sync_q[1]};
            dat_hist_q <= {dat_hist_q[0], dat_sync_q[1]};
            clk_filt_q <= clk_filt_d;
            dat_filt_q <= dat_filt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= RX_IDLE;
            bitcnt_q     <= '0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            timer_q      <= '0;
            byte_valid_q <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            if (fall) begin
                timer_q <= '0;
                unique case (state_q)
                    RX_IDLE: begin
                        if (!dat_filt_q) begin
                            state_q  <= RX_DATA;
                            bitcnt_q <= '0;
                        end
                    end
                    RX_DATA: begin
                        shreg_q  <= {dat_filt_q, shreg_q[7:1]};
                        bitcnt_q <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7)
                            state_q <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        par_q   <= dat_filt_q;
                        state_q <= RX_STOP;
                    end
                    RX_STOP: begin
                        if (!dat_filt_q)
                            ferr_q <= 1'b1;
                        else if (!parity_ok({par_q, shreg_q}))
                            perr_q <= 1'b1;
                        else
                            byte_valid_q <= 1'b1;
                        state_q <= RX_IDLE;
                    end
                    default: state_q <= RX_IDLE;
                endcase
            end else if (state_q != RX_IDLE) begin
                if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_q <= RX_IDLE;
                    timer_q <= '0;
                end else begin
                    timer_q <= timer_q + TW'(1);
                end
            end
        end
    end

    assign byte_valid_o = byte_valid_q;
    assign byte_o       = shreg_q;
    assign perr_p_o     = perr_q;
    assign ferr_p_o     = ferr_q;
    assign busy_o       = (state_q != RX_IDLE);

endmodule

// File: rtl/ps2_kbd.sv
// Memory-mapped PS/2 keyboard port: scan-code FIFO, status/control and data
// registers on the 6502 bus, and the IRQ contribution.
module ps2_kbd
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned TIMEOUT_CYC = 8000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       we,
    input  logic       rs,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq,
    input  logic       ps2_clk,
    input  logic       ps2_dat
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic          rx_valid, rx_perr, rx_ferr, rx_busy;
    logic [7:0]    rx_byte;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q, wptr_d, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovr_q, perr_q, ferr_q, ien_q, irq_q;
    logic          ovr_d, perr_d, ferr_d, ien_d, irq_d;
    logic [7:0]    dout_q, dout_d;

    logic          rd_access, ctl_write, avail, full, pop, push_ok, clr;
    logic [7:0]    status;
    logic          unused_din;

    ps2_rx #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk          (clk),
        .rst_ni       (reset),
        .ps2_clk_i    (ps2_clk),
        .ps2_dat_i    (ps2_dat),
        .byte_valid_o (rx_valid),
        .byte_o       (rx_byte),
        .perr_p_o     (rx_perr),
        .ferr_p_o     (rx_ferr),
        .busy_o       (rx_busy)
    );

    assign unused_din = ^din[6:1];

    always_comb begin
        rd_access = cs & ~we;
        ctl_write = cs & we & ~rs;
        avail     = (count_q != '0);
        full      = (count_q == (AW+1)'(FIFO_DEPTH));
        pop       = rd_access & rs & avail;
        // A pop in the same cycle frees the slot, so a push at full still lands
        push_ok   = rx_valid & (~full | pop);
        clr       = ctl_write & din[CTL_CLR];

        status          = '0;
        status[ST_AVAIL] = avail;
        status[ST_FULL]  = full;
        status[ST_OVR]   = ovr_q;
        status[ST_PERR]  = perr_q;
        status[ST_FERR]  = ferr_q;
        status[ST_IEN]   = ien_q;
        status[ST_BUSY]  = rx_busy;
        status[ST_IRQ]   = irq_q;

        wptr_d  = push_ok ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        if (push_ok && !pop)
            count_d = count_q + (AW+1)'(1);
        else if (pop && !push_ok)
            count_d = count_q - (AW+1)'(1);

        ovr_d  = (ovr_q  & ~clr) | (rx_valid & full & ~pop);
        perr_d = (perr_q & ~clr) | rx_perr;
        ferr_d = (ferr_q & ~clr) | rx_ferr;
        ien_d  = ctl_write ? din[CTL_IEN] : ien_q;
        irq_d  = ien_q & (avail | ovr_q | perr_q | ferr_q);

        dout_d = dout_q;
        if (rd_access)
            dout_d = rs ? (avail ? mem_q[rptr_q] : 8'h00) : status;
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wptr_q] <= rx_byte;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ien_q   <= 1'b0;
            irq_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ien_q   <= ien_d;
            irq_q   <= irq_d;
            dout_q  <= dout_d;
        end
    end

    assign dout = dout_q;
    assign irq  = irq_q;

endmodule

// File: tb/tb_ps2_kbd.sv
// Self-checking bench for ps2_kbd: frame vector table plus hand sequences for
// overrun, timeout, glitch rejection, push/pop collision and IRQ.
module tb_ps2_kbd;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 300;
    localparam int unsigned HALF  = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cs = 1'b0, we = 1'b0, rs = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic       irq;
    logic       ps2_clk = 1'b1, ps2_dat = 1'b1;

    always #5 clk = ~clk;

    ps2_kbd #(
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .we      (we),
        .rs      (rs),
        .din     (din),
        .dout    (dout),
        .irq     (irq),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat)
    );

    typedef struct {
        logic [7:0] data;
        logic       bad_par;
        logic       bad_stop;
        logic [7:0] exp_status;
    } vec_t;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] sb_q [$];
    logic       m_ovr = 1'b0;
    vec_t       vt [7];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic model_push(input logic [7:0] b);
        if (sb_q.size() < DEPTH) sb_q.push_back(b);
        else m_ovr = 1'b1;
    endtask

    function automatic logic [7:0] model_status();
        logic [7:0] s;
        s = '0;
        s[0] = (sb_q.size() != 0);
        s[1] = (sb_q.size() == DEPTH);
        s[2] = m_ovr;
        return s;
    endfunction

    task automatic bus_read(input logic r, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b0; rs = r;
        @(posedge clk);
        #1;
        cs = 1'b0;
        d = dout;
    endtask

    task automatic bus_write(input logic r, input logic [7:0] v);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; rs = r; din = v;
        @(posedge clk);
        #1;
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic check_status(input string name, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(1'b0, d);
        check(name, d, exp);
    endtask

    task automatic read_data_sb(input string name);
        logic [7:0] d, exp;
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : 8'h00;
        bus_read(1'b1, d);
        check(name, d, exp);
    endtask

    // The collision read is placed so its address cycle ends on the push edge
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                              input int nbits, input logic collide);
        logic [10:0] f;
        logic [7:0]  d, exp;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_dat = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (collide && i == 10) begin
                repeat (5) @(posedge clk);
                @(negedge clk);
                cs = 1'b1; we = 1'b0; rs = 1'b1;
                exp = (sb_q.size() != 0) ? sb_q.pop_front() : 8'h00;
                @(posedge clk);
                #1;
                cs = 1'b0;
                d = dout;
                check("collide_read", d, exp);
            end
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        @(negedge clk);
        ps2_dat = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    initial begin
        int n;
        vt[0] = '{8'h1C, 1'b0, 1'b0, 8'h01};
        vt[1] = '{8'h1C, 1'b1, 1'b0, 8'h08};
        vt[2] = '{8'hF0, 1'b0, 1'b1, 8'h10};
        vt[3] = '{8'h00, 1'b0, 1'b0, 8'h01};
        vt[4] = '{8'hFF, 1'b0, 1'b0, 8'h01};
        vt[5] = '{8'hA5, 1'b1, 1'b0, 8'h08};
        vt[6] = '{8'h5A, 1'b0, 1'b1, 8'h10};

        repeat (5) @(posedge clk);
        #1;
        check("reset_dout", dout, 8'h00);
        check("reset_irq", {7'b0, irq}, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_status("reset_status", 8'h00);

        for (int i = 0; i < 7; i++) begin
            send_frame(vt[i].data, vt[i].bad_par, vt[i].bad_stop, 11, 1'b0);
            if (!vt[i].bad_par && !vt[i].bad_stop) model_push(vt[i].data);
            check_status($sformatf("vec%0d_status", i), vt[i].exp_status);
            while (sb_q.size() != 0) read_data_sb($sformatf("vec%0d_data", i));
            read_data_sb($sformatf("vec%0d_empty", i));
            bus_write(1'b0, 8'h01);
            check_status($sformatf("vec%0d_clear", i), 8'h00);
        end

        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1'b0, 1'b0, 11, 1'b0);
            model_push(8'(i));
        end
        check_status("fill_status", model_status());
        for (int i = 0; i < 9; i++) read_data_sb($sformatf("fill_read%0d", i));
        check_status("fill_drained", model_status());
        bus_write(1'b0, 8'h01);
        m_ovr = 1'b0;
        check_status("fill_clear", 8'h00);

        send_frame(8'h33, 1'b0, 1'b0, 4, 1'b0);
        check_status("tmo_busy", 8'h40);
        repeat (TMO + 10) @(negedge clk);
        check_status("tmo_idle", 8'h00);
        read_data_sb("tmo_empty");

        @(negedge clk);
        ps2_dat = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
        check_status("glitch_ignored", 8'h00);
        ps2_dat = 1'b1;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            send_frame(8'h11 + 8'(i), 1'b0, 1'b0, 11, 1'b0);
            model_push(8'h11 + 8'(i));
        end
        check_status("coll_full", 8'h03);
        send_frame(8'h19, 1'b0, 1'b0, 11, 1'b1);
        model_push(8'h19);
        check_status("coll_no_ovr", model_status());
        for (int i = 0; i < 9; i++) read_data_sb($sformatf("coll_read%0d", i));
        check_status("coll_empty", 8'h00);

        bus_write(1'b0, 8'h80);
        check_status("ien_status", 8'h20);
        check("irq_idle", {7'b0, irq}, 8'h00);
        send_frame(8'h5A, 1'b0, 1'b0, 11, 1'b0);
        model_push(8'h5A);
        n = 0;
        while (!irq && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("irq_rise", {7'b0, irq}, 8'h01);
        check_status("irq_status", 8'hA1);
        read_data_sb("irq_data");
        check("irq_hold", {7'b0, irq}, 8'h01);
        @(posedge clk);
        #1;
        check("irq_drop", {7'b0, irq}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
